// File: rtl/fip_32_div_if.sv
// Operand/result handshake bundle for the Q16.16 fixed-point divider.
// master drives operands and out_ready; slave is the divider.
interface fip_32_div_if #(
  parameter int unsigned WIDTH = 32
);
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] quot;
  logic             overflow;
  logic             div_by_zero;
  logic             out_valid;
  logic             out_ready;

  modport master (
    output x, y, in_valid, out_ready,
    input  in_ready, quot, overflow, div_by_zero, out_valid
  );

  modport slave (
    input  x, y, in_valid, out_ready,
    output in_ready, quot, overflow, div_by_zero, out_valid
  );
endinterface

// File: rtl/fip_32_div.sv
// Sequential signed Q16.16 divider: restoring, sign-magnitude, one quotient bit per
// cycle. Saturates on range overflow and on divide-by-zero.
module fip_32_div #(
  parameter int unsigned INT_SHIFT = 16,
  parameter int unsigned WIDTH     = 32
) (
  input logic          clk,
  input logic          reset_n,
  fip_32_div_if.slave  bus
);
  localparam int unsigned ITER = WIDTH + INT_SHIFT;
  localparam int unsigned CW   = $clog2(ITER + 1);

  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
  localparam logic [WIDTH-1:0] POS_MAX = {1'b0, {(WIDTH - 1){1'b1}}};
  localparam logic [WIDTH-1:0] NEG_MAX = {1'b1, {(WIDTH - 1){1'b0}}};

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [CW-1:0]    count_q;
  logic [ITER-1:0]  dividend_q;
  logic [ITER-1:0]  qmag_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] ymag_q;
  logic             sign_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] quot_q;
  logic             overflow_q;
  logic             div_by_zero_q;

  logic [WIDTH-1:0] xabs, yabs;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH-1:0] rem_sub;
  logic             rem_ge;
  logic [ITER-1:0]  q_next;
  logic             q_pos_ovf, q_neg_ovf;
  logic [WIDTH-1:0] q_neg;

  always_comb begin
    // |most-negative| is 2^(WIDTH-1), representable as unsigned
    xabs      = bus.x[WIDTH-1] ? (~bus.x + ONE) : bus.x;
    yabs      = bus.y[WIDTH-1] ? (~bus.y + ONE) : bus.y;
    rem_sh    = {rem_q, dividend_q[ITER-1]};
    rem_ge    = rem_sh >= {1'b0, ymag_q};
    // Only used when rem_ge, where the true difference fits in WIDTH bits
    rem_sub   = rem_sh[WIDTH-1:0] - ymag_q;
    q_next    = {qmag_q[ITER-2:0], rem_ge};
    q_pos_ovf = q_next > {{INT_SHIFT{1'b0}}, POS_MAX};
    q_neg_ovf = q_next > {{INT_SHIFT{1'b0}}, NEG_MAX};
    q_neg     = ~q_next[WIDTH-1:0] + ONE;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= StIdle;
      count_q       <= '0;
      dividend_q    <= '0;
      qmag_q        <= '0;
      rem_q         <= '0;
      ymag_q        <= '0;
      sign_q        <= 1'b0;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      quot_q        <= '0;
      overflow_q    <= 1'b0;
      div_by_zero_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.in_valid && in_ready_q) begin
            in_ready_q    <= 1'b0;
            sign_q        <= bus.x[WIDTH-1] ^ bus.y[WIDTH-1];
            ymag_q        <= yabs;
            dividend_q    <= {xabs, {INT_SHIFT{1'b0}}};
            rem_q         <= '0;
            qmag_q        <= '0;
            count_q       <= '0;
            overflow_q    <= 1'b0;
            div_by_zero_q <= 1'b0;
            if (bus.y == '0) begin
              state_q       <= StDone;
              overflow_q    <= 1'b1;
              div_by_zero_q <= 1'b1;
              quot_q        <= bus.x[WIDTH-1] ? NEG_MAX : POS_MAX;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          rem_q      <= rem_ge ? rem_sub : rem_sh[WIDTH-1:0];
          dividend_q <= dividend_q << 1;
          qmag_q     <= q_next;
          count_q    <= count_q + CW'(1);
          if (count_q == CW'(ITER - 1)) begin
            state_q <= StDone;
            if (!sign_q) begin
              overflow_q <= q_pos_ovf;
              quot_q     <= q_pos_ovf ? POS_MAX : q_next[WIDTH-1:0];
            end else begin
              overflow_q <= q_neg_ovf;
              quot_q     <= q_neg_ovf ? NEG_MAX : q_neg;
            end
          end
        end
        StDone: begin
          // out_valid rises one cycle after entering DONE
          if (out_valid_q && bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= StIdle;
          end else begin
            out_valid_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.quot        = quot_q;
  assign bus.overflow    = overflow_q;
  assign bus.div_by_zero = div_by_zero_q;
endmodule
